branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It is a direct-mapped BTB with per-entry saturating direction counters.
- Fetch: looks up the next PC in the same cycle.
- Internally: carries each prediction through decode and execute in shadow registers that obey the pipeline stall/flush controls.
- Execute: resolves the prediction, flags mispredicts with the corrective PC, and keeps branch and mispredict statistics.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_table.sv | 112 +++++++++++
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   idx_w / tag_w  : BTB index and tag widths for a given geometry.
//   ctr_weak_nt, ctr_weak_t, ctr_strong_t : direction-counter constants
//                    derived from the counter width (01..1, 10..0, 11..1).
// The entry and prediction structs depend on module parameters, so they are
// declared in the modules from these widths.
package bp_pkg;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  function automatic int ctr_weak_t(input int bits);
    return 1 << (bits - 1);
  endfunction

  function automatic int ctr_weak_nt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_strong_t(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   rd_pc                   : lookup PC (combinational read port)
//   rd_taken, rd_target     : prediction for rd_pc (miss -> not taken, pc+4)
//   wr_en                   : resolved branch/jump commits this edge
//   wr_pc, wr_taken,
//   wr_jump, wr_target      : resolved instruction PC, direction, jump flag, target
module bp_table
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic            wr_jump,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(XLEN, ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT  = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T   = CTR_BITS'(ctr_weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_STRONG_T = CTR_BITS'(ctr_strong_t(CTR_BITS));

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } btb_entry_t;

  btb_entry_t tbl [ENTRIES];

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_STRONG_T) ? c : c + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // Instructions are word aligned; the low PC bits carry no index/tag info.
  logic rd_pc_unused;
  logic wr_pc_unused;
  assign rd_pc_unused = ^rd_pc[1:0];
  assign wr_pc_unused = ^wr_pc[1:0];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  btb_entry_t       rd_entry;
  logic             rd_hit;

  assign rd_idx    = rd_pc[IDX_W+1:2];
  assign rd_tag    = rd_pc[XLEN-1:IDX_W+2];
  assign rd_entry  = tbl[rd_idx];
  assign rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_taken  = rd_hit && rd_entry.ctr[CTR_BITS-1];
  assign rd_target = rd_taken ? rd_entry.target : rd_pc + XLEN'(4);

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  btb_entry_t       wr_entry;
  logic             wr_hit;

  assign wr_idx   = wr_pc[IDX_W+1:2];
  assign wr_tag   = wr_pc[XLEN-1:IDX_W+2];
  assign wr_entry = tbl[wr_idx];
  assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

  // Reads are combinational from the registered array, so a same-cycle
  // lookup always observes the contents before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid  <= 1'b0;
        tbl[i].tag    <= '0;
        tbl[i].target <= '0;
        tbl[i].ctr    <= CTR_WEAK_NT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          tbl[wr_idx].ctr    <= ctr_inc(wr_entry.ctr);
          tbl[wr_idx].target <= wr_target;
        end else begin
          tbl[wr_idx].ctr <= ctr_dec(wr_entry.ctr);
        end
      end else if (wr_taken) begin
        tbl[wr_idx].valid  <= 1'b1;
        tbl[wr_idx].tag    <= wr_tag;
        tbl[wr_idx].target <= wr_target;
        tbl[wr_idx].ctr    <= CTR_WEAK_T;
      end
      // Jumps always go strongly taken; a not-taken miss leaves another
      // PC's entry alone, so the override is limited to the owned entry.
      if (wr_jump && (wr_hit || wr_taken)) begin
        tbl[wr_idx].ctr <= CTR_STRONG_T;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the 5-stage pipeline.
// Fetch-stage lookup is combinational; each prediction rides decode and
// execute shadow slots (obeying Stall/Flush) and is resolved in execute.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   PC_fe                           : fetch PC
//   PredTaken_fe, PredTarget_fe     : fetch prediction
//   Stall, Flush                    : pipeline controls (Flush wins)
//   Valid_ex, IsBr_ex, IsJump_ex,
//   Taken_ex, Target_ex, PC_ex      : resolved execute-stage instruction
//   Mispredict_ex, Redirect_ex      : mispredict flag and corrective PC
//   BranchCnt, MispredCnt           : saturating statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     PC_fe,
  output logic                PredTaken_fe,
  output logic [XLEN-1:0]     PredTarget_fe,
  input  logic                Stall,
  input  logic                Flush,
  input  logic                Valid_ex,
  input  logic                IsBr_ex,
  input  logic                IsJump_ex,
  input  logic                Taken_ex,
  input  logic [XLEN-1:0]     Target_ex,
  input  logic [XLEN-1:0]     PC_ex,
  output logic                Mispredict_ex,
  output logic [XLEN-1:0]     Redirect_ex,
  output logic [CNT_BITS-1:0] BranchCnt,
  output logic [CNT_BITS-1:0] MispredCnt
);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } pred_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + CNT_BITS'(1);
  endfunction

  logic br_ex;
  assign br_ex = Valid_ex && IsBr_ex;

  bp_table #(
    .XLEN     (XLEN),
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (PC_fe),
    .rd_taken  (PredTaken_fe),
    .rd_target (PredTarget_fe),
    .wr_en     (br_ex),
    .wr_pc     (PC_ex),
    .wr_taken  (Taken_ex),
    .wr_jump   (IsJump_ex),
    .wr_target (Target_ex)
  );

  pred_t pred_fe;
  pred_t slot_de_p0;
  pred_t slot_ex_p1;

  assign pred_fe = '{taken: PredTaken_fe, target: PredTarget_fe};

  // Fetch -> decode slot -> execute slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_de_p0 <= '0;
      slot_ex_p1 <= '0;
    end else if (Flush) begin
      slot_de_p0 <= '0;
      slot_ex_p1 <= '0;
    end else if (Stall) begin
      slot_ex_p1 <= '0;
    end else begin
      slot_de_p0 <= pred_fe;
      slot_ex_p1 <= slot_de_p0;
    end
  end

  // Execute-stage resolution
  always_comb begin
    Mispredict_ex = 1'b0;
    if (Valid_ex) begin
      if (IsBr_ex) begin
        Mispredict_ex = (Taken_ex != slot_ex_p1.taken) ||
                        (Taken_ex && (Target_ex != slot_ex_p1.target));
      end else begin
        Mispredict_ex = slot_ex_p1.taken;
      end
    end
  end

  assign Redirect_ex = (IsBr_ex && Taken_ex) ? Target_ex : PC_ex + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (br_ex)         BranchCnt  <= sat_inc(BranchCnt);
      if (Mispredict_ex) MispredCnt <= sat_inc(MispredCnt);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_fe;
  logic        PredTaken_fe;
  logic [31:0] PredTarget_fe;
  logic        Stall;
  logic        Flush;
  logic        Valid_ex;
  logic        IsBr_ex;
  logic        IsJump_ex;
  logic        Taken_ex;
  logic [31:0] Target_ex;
  logic [31:0] PC_ex;
  logic        Mispredict_ex;
  logic [31:0] Redirect_ex;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int n_vec = 0;
  int n_err = 0;

  branch_predictor #(
    .XLEN(32), .ENTRIES(16), .CTR_BITS(2), .CNT_BITS(32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_fe         (PC_fe),
    .PredTaken_fe  (PredTaken_fe),
    .PredTarget_fe (PredTarget_fe),
    .Stall         (Stall),
    .Flush         (Flush),
    .Valid_ex      (Valid_ex),
    .IsBr_ex       (IsBr_ex),
    .IsJump_ex     (IsJump_ex),
    .Taken_ex      (Taken_ex),
    .Target_ex     (Target_ex),
    .PC_ex         (PC_ex),
    .Mispredict_ex (Mispredict_ex),
    .Redirect_ex   (Redirect_ex),
    .BranchCnt     (BranchCnt),
    .MispredCnt    (MispredCnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fetch pc, let its prediction reach execute, then resolve it there.
  // Returns the combinational resolution seen just before the update edge.
  task automatic run_branch(input logic [31:0] pc, input logic tk, input logic jmp,
                            input logic [31:0] tgt, output logic mis, output logic [31:0] red);
    PC_fe = pc; Valid_ex = 1'b0;
    tick();
    PC_fe = 32'h1000;
    tick();
    Valid_ex = 1'b1; IsBr_ex = 1'b1; IsJump_ex = jmp; Taken_ex = tk;
    Target_ex = tgt; PC_ex = pc;
    #1;
    mis = Mispredict_ex; red = Redirect_ex;
    tick();
    Valid_ex = 1'b0; IsBr_ex = 1'b0; IsJump_ex = 1'b0; Taken_ex = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    PC_fe = 32'h40;
    #1;
    n_vec++; if (PredTaken_fe !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", PredTaken_fe); end
    n_vec++; if (PredTarget_fe !== 32'h44) begin n_err++; $display("FAIL reset_target: got %h want 00000044", PredTarget_fe); end
    n_vec++; if (BranchCnt !== 32'd0) begin n_err++; $display("FAIL reset_brcnt: got %0d want 0", BranchCnt); end
    n_vec++; if (MispredCnt !== 32'd0) begin n_err++; $display("FAIL reset_miscnt: got %0d want 0", MispredCnt); end
    n_vec++; if (Mispredict_ex !== 1'b0) begin n_err++; $display("FAIL reset_mispredict: got %b want 0", Mispredict_ex); end
  endtask

  task automatic test_first_taken;
    logic m; logic [31:0] r;
    run_branch(32'h40, 1'b1, 1'b0, 32'h20, m, r);
    n_vec++; if (m !== 1'b1) begin n_err++; $display("FAIL first_mis: got %b want 1", m); end
    n_vec++; if (r !== 32'h20) begin n_err++; $display("FAIL first_redirect: got %h want 00000020", r); end
    n_vec++; if (MispredCnt !== 32'd1) begin n_err++; $display("FAIL first_miscnt: got %0d want 1", MispredCnt); end
    n_vec++; if (BranchCnt !== 32'd1) begin n_err++; $display("FAIL first_brcnt: got %0d want 1", BranchCnt); end
    PC_fe = 32'h40; #1;
    n_vec++; if (PredTaken_fe !== 1'b1) begin n_err++; $display("FAIL first_pred_taken: got %b want 1", PredTaken_fe); end
    n_vec++; if (PredTarget_fe !== 32'h20) begin n_err++; $display("FAIL first_pred_target: got %h want 00000020", PredTarget_fe); end
  endtask

  task automatic test_hysteresis;
    logic m; logic [31:0] r;
    run_branch(32'h40, 1'b1, 1'b0, 32'h20, m, r);  // ctr 10 -> 11
    n_vec++; if (m !== 1'b0) begin n_err++; $display("FAIL hyst_t1_mis: got %b want 0", m); end
    run_branch(32'h40, 1'b1, 1'b0, 32'h20, m, r);  // ctr stays 11
    n_vec++; if (m !== 1'b0) begin n_err++; $display("FAIL hyst_t2_mis: got %b want 0", m); end
    run_branch(32'h40, 1'b0, 1'b0, 32'h20, m, r);  // ctr 11 -> 10
    n_vec++; if (m !== 1'b1) begin n_err++; $display("FAIL hyst_nt1_mis: got %b want 1", m); end
    n_vec++; if (r !== 32'h44) begin n_err++; $display("FAIL hyst_nt1_redirect: got %h want 00000044", r); end
    PC_fe = 32'h40; #1;
    n_vec++; if (PredTaken_fe !== 1'b1) begin n_err++; $display("FAIL hyst_after_nt1_taken: got %b want 1", PredTaken_fe); end
    run_branch(32'h40, 1'b0, 1'b0, 32'h20, m, r);  // predicted taken (10), ctr -> 01
    n_vec++; if (m !== 1'b1) begin n_err++; $display("FAIL hyst_nt2_mis: got %b want 1", m); end
    PC_fe = 32'h40; #1;
    n_vec++; if (PredTaken_fe !== 1'b0) begin n_err++; $display("FAIL hyst_after_nt2_taken: got %b want 0", PredTaken_fe); end
    n_vec++; if (PredTarget_fe !== 32'h44) begin n_err++; $display("FAIL hyst_after_nt2_target: got %h want 00000044", PredTarget_fe); end
    run_branch(32'h40, 1'b0, 1'b0, 32'h20, m, r);  // predicted not taken, ctr -> 00
    n_vec++; if (m !== 1'b0) begin n_err++; $display("FAIL hyst_nt3_mis: got %b want 0", m); end
    n_vec++; if (BranchCnt !== 32'd6) begin n_err++; $display("FAIL hyst_brcnt: got %0d want 6", BranchCnt); end
    n_vec++; if (MispredCnt !== 32'd3) begin n_err++; $display("FAIL hyst_miscnt: got %0d want 3", MispredCnt); end
  endtask

  task automatic test_alias;
    logic m; logic [31:0] r;
    run_branch(32'h40, 1'b1, 1'b0, 32'h20, m, r);  // 00 -> 01
    run_branch(32'h40, 1'b1, 1'b0, 32'h20, m, r);  // 01 -> 10
    PC_fe = 32'h40; #1;
    n_vec++; if (PredTaken_fe !== 1'b1) begin n_err++; $display("FAIL alias_40_taken: got %b want 1", PredTaken_fe); end
    PC_fe = 32'h80; #1;
    n_vec++; if (PredTaken_fe !== 1'b0) begin n_err++; $display("FAIL alias_80_miss: got %b want 0", PredTaken_fe); end
    n_vec++; if (PredTarget_fe !== 32'h84) begin n_err++; $display("FAIL alias_80_target: got %h want 00000084", PredTarget_fe); end
    run_branch(32'h80, 1'b1, 1'b0, 32'h300, m, r);
    n_vec++; if (m !== 1'b1) begin n_err++; $display("FAIL alias_80_mis: got %b want 1", m); end
    n_vec++; if (r !== 32'h300) begin n_err++; $display("FAIL alias_80_redirect: got %h want 00000300", r); end
    PC_fe = 32'h80; #1;
    n_vec++; if (PredTarget_fe !== 32'h300) begin n_err++; $display("FAIL alias_80_alloc_target: got %h want 00000300", PredTarget_fe); end
    PC_fe = 32'h40; #1;
    n_vec++; if (PredTaken_fe !== 1'b0) begin n_err++; $display("FAIL alias_40_evicted: got %b want 0", PredTaken_fe); end
    n_vec++; if (BranchCnt !== 32'd9 || MispredCnt !== 32'd6) begin n_err++; $display("FAIL alias_counts: got %0d/%0d want 9/6", BranchCnt, MispredCnt); end
  endtask

  task automatic test_stall_flush;
    // Stall: predicted-taken 0x80 sits in decode, execute gets a bubble.
    PC_fe = 32'h80; tick();
    PC_fe = 32'h1000; Stall = 1'b1; tick();
    #1;
    n_vec++; if (Mispredict_ex !== 1'b0) begin n_err++; $display("FAIL stall_novalid_mis: got %b want 0", Mispredict_ex); end
    Valid_ex = 1'b1; #1;
    n_vec++; if (Mispredict_ex !== 1'b0) begin n_err++; $display("FAIL stall_bubble_mis: got %b want 0", Mispredict_ex); end
    Valid_ex = 1'b0; Stall = 1'b0; tick();
    Valid_ex = 1'b1; #1;
    n_vec++; if (Mispredict_ex !== 1'b1) begin n_err++; $display("FAIL stall_held_de_mis: got %b want 1", Mispredict_ex); end
    Valid_ex = 1'b0;
    // Stall and Flush together clear both slots.
    PC_fe = 32'h80; tick(); tick();
    Stall = 1'b1; Flush = 1'b1; tick();
    Stall = 1'b0; Flush = 1'b0; PC_fe = 32'h1000;
    Valid_ex = 1'b1; #1;
    n_vec++; if (Mispredict_ex !== 1'b0) begin n_err++; $display("FAIL flush_ex_mis: got %b want 0", Mispredict_ex); end
    Valid_ex = 1'b0; tick();
    Valid_ex = 1'b1; #1;
    n_vec++; if (Mispredict_ex !== 1'b0) begin n_err++; $display("FAIL flush_de_mis: got %b want 0", Mispredict_ex); end
    Valid_ex = 1'b0; #1;
    n_vec++; if (BranchCnt !== 32'd9 || MispredCnt !== 32'd6) begin n_err++; $display("FAIL stall_counts: got %0d/%0d want 9/6", BranchCnt, MispredCnt); end
  endtask

  task automatic test_jump_reset;
    logic m; logic [31:0] r;
    run_branch(32'h100, 1'b1, 1'b1, 32'h200, m, r);
    n_vec++; if (m !== 1'b1 || r !== 32'h200) begin n_err++; $display("FAIL jal_resolve: got %b/%h want 1/00000200", m, r); end
    PC_fe = 32'h100; #1;
    n_vec++; if (PredTaken_fe !== 1'b1 || PredTarget_fe !== 32'h200) begin n_err++; $display("FAIL jal_pred: got %b/%h want 1/00000200", PredTaken_fe, PredTarget_fe); end
    // One not-taken leaves a strongly-taken counter still predicting taken.
    run_branch(32'h100, 1'b0, 1'b0, 32'h200, m, r);
    n_vec++; if (m !== 1'b1 || r !== 32'h104) begin n_err++; $display("FAIL jal_nt_resolve: got %b/%h want 1/00000104", m, r); end
    PC_fe = 32'h100; #1;
    n_vec++; if (PredTaken_fe !== 1'b1) begin n_err++; $display("FAIL jal_strong_ctr: got %b want 1", PredTaken_fe); end
    n_vec++; if (BranchCnt !== 32'd11 || MispredCnt !== 32'd8) begin n_err++; $display("FAIL jal_counts: got %0d/%0d want 11/8", BranchCnt, MispredCnt); end
    // Reset asserted mid-cycle while an update is being presented.
    Valid_ex = 1'b1; IsBr_ex = 1'b1; IsJump_ex = 1'b1; Taken_ex = 1'b1;
    PC_ex = 32'h100; Target_ex = 32'h999;
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin n_err++; $display("FAIL rst_counts: got %0d/%0d want 0/0", BranchCnt, MispredCnt); end
    n_vec++; if (PredTaken_fe !== 1'b0 || PredTarget_fe !== 32'h104) begin n_err++; $display("FAIL rst_lookup: got %b/%h want 0/00000104", PredTaken_fe, PredTarget_fe); end
    tick();
    Valid_ex = 1'b0; IsBr_ex = 1'b0; IsJump_ex = 1'b0; Taken_ex = 1'b0;
    rst_n = 1'b1; #1;
    n_vec++; if (PredTaken_fe !== 1'b0 || PredTarget_fe !== 32'h104) begin n_err++; $display("FAIL rst_after_lookup: got %b/%h want 0/00000104", PredTaken_fe, PredTarget_fe); end
    n_vec++; if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0 || Mispredict_ex !== 1'b0) begin n_err++; $display("FAIL rst_after_state: got %0d/%0d/%b want 0/0/0", BranchCnt, MispredCnt, Mispredict_ex); end
  endtask

  initial begin
    rst_n = 1'b0; PC_fe = '0; Stall = 1'b0; Flush = 1'b0;
    Valid_ex = 1'b0; IsBr_ex = 1'b0; IsJump_ex = 1'b0; Taken_ex = 1'b0;
    Target_ex = '0; PC_ex = '0;
    test_reset();
    test_first_taken();
    test_hysteresis();
    test_alias();
    test_stall_flush();
    test_jump_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
